// File: rtl/pwm_peripheral.sv
// pwm_peripheral: drives 16 chip outputs from the SPI register file settings.
// Each output is forced low, held high, or follows a shared 8-bit PWM level
// produced by a prescaled 8-bit period counter.
//
// Optional feature macro: PWM_SHADOW_EN
//   defined   - duty value is shadowed and only reloaded at the counter wrap,
//               so a period is never truncated or extended mid-way.
//   undefined - duty value feeds the comparator directly.
module pwm_peripheral #(
    parameter int CLK_DIV = 3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam int            PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [7:0]    count_q, count_d;
    logic [15:0]   out_q, out_d;
    logic          period_start_q, period_start_d;

    logic          tick;
    logic          wrap;
    logic [7:0]    duty_act;
    logic          pwm_level;
    logic [15:0]   en_out;
    logic [15:0]   en_pwm;

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    assign tick = (pre_q == PRE_MAX);
    assign wrap = tick && (count_q == 8'hFF);

`ifdef PWM_SHADOW_EN
    logic [7:0] duty_q, duty_d;

    // Shadow duty: reload only as the counter wraps so each period is whole.
    always_comb begin
        duty_d = duty_q;
        if (wrap) begin
            duty_d = pwm_duty_cycle;
        end
    end

    // Shadow duty register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= 8'h00;
        end else begin
            duty_q <= duty_d;
        end
    end

    assign duty_act = duty_q;
`else
    assign duty_act = pwm_duty_cycle;
`endif

    // 0xFF is treated as full-on so there is no low count at 255.
    assign pwm_level = (duty_act == 8'hFF) || (count_q < duty_act);

    // Next-state for prescaler, period counter, outputs and wrap pulse.
    always_comb begin
        pre_d          = pre_q + PW'(1);
        count_d        = count_q;
        if (tick) begin
            pre_d   = '0;
            count_d = count_q + 8'd1;
        end
        out_d          = en_out & (~en_pwm | {16{pwm_level}});
        period_start_d = wrap;
    end

    // State registers; reset clears outputs immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q          <= '0;
            count_q        <= 8'h00;
            out_q          <= 16'h0000;
            period_start_q <= 1'b0;
        end else begin
            pre_q          <= pre_d;
            count_q        <= count_d;
            out_q          <= out_d;
            period_start_q <= period_start_d;
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral with CLK_DIV = 4 (1024-cycle period).
// Expected per-period measurements are queued by the stimulus; a monitor
// measures each period between period_start pulses and checks the queue.
module tb_pwm_peripheral;

    localparam int CLK_DIV = 4;
    localparam int PERIOD  = 256 * CLK_DIV;
    localparam int BOUND   = 3 * PERIOD;

`ifdef PWM_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;
    logic        period_start;

    pwm_peripheral #(.CLK_DIV(CLK_DIV)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .out             (out),
        .period_start    (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        int          high;
        logic [15:0] others;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   mon_period = 0;
    int   acc_high = 0;
    logic [15:0] acc_or = 16'h0000;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got=%0d (0x%0h) want=%0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic push(input int idx, input int high, input logic [15:0] others,
                        input string name);
        exp_t e;
        e.idx = idx; e.high = high; e.others = others; e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: accumulate out[0] high time and other-bit activity per period.
    always @(negedge clk) begin
        if (!rst_n) begin
            acc_high = 0;
            acc_or   = 16'h0000;
        end else begin
            acc_high += int'(out[0]);
            acc_or   |= out & 16'hFFFE;
            if (period_start) begin
                while (sb.size() > 0 && sb[0].idx < mon_period) begin
                    chk({sb[0].name, "_missed"}, sb[0].idx, mon_period);
                    void'(sb.pop_front());
                end
                if (sb.size() > 0 && sb[0].idx == mon_period) begin
                    chk({sb[0].name, "_high"}, acc_high, sb[0].high);
                    chk({sb[0].name, "_others"}, int'(acc_or), int'(sb[0].others));
                    void'(sb.pop_front());
                end
                mon_period++;
                acc_high = 0;
                acc_or   = 16'h0000;
            end
        end
    end

    // Returns 1 ns after the rising edge at which period_start is seen high.
    task automatic wait_ps(output int cyc);
        bit found;
        found = 1'b0;
        cyc   = 0;
        while (!found && cyc < BOUND) begin
            @(posedge clk);
            #1;
            cyc++;
            if (period_start) found = 1'b1;
        end
        if (!found) chk("period_start_timeout", cyc, -1);
    endtask

    task automatic set_in(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        en_reg_out_7_0  = eo[7:0];
        en_reg_out_15_8 = eo[15:8];
        en_reg_pwm_7_0  = ep[7:0];
        en_reg_pwm_15_8 = ep[15:8];
        pwm_duty_cycle  = d;
    endtask

    // Apply settings, let one boundary pass, then check n whole periods.
    task automatic run_case(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d,
                            input int n, input int high, input logic [15:0] others,
                            input string name);
        int c;
        set_in(eo, ep, d);
        wait_ps(c);
        for (int i = 0; i < n; i++) push(mon_period + 1 + i, high, others, name);
        repeat (n) wait_ps(c);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int k;
        rst_n = 1'b0;
        set_in(16'hFFFF, 16'hFFFF, 8'hFF);

        // Reset hold with all inputs high.
        repeat (3) @(negedge clk);
        chk("reset_out", int'(out), 0);
        chk("reset_ps", int'(period_start), 0);

        // First period after release: full-on without shadow, low with shadow.
        push(0, SHADOW ? 0 : PERIOD, SHADOW ? 16'h0000 : 16'hFFFE, "first_period");
        rst_n = 1'b1;
        wait_ps(c);
        chk("first_ps_latency", c, PERIOD);

        run_case(16'h0001, 16'h0001, 8'h80, 1, 512, 16'h0000, "duty80");
        run_case(16'h0001, 16'h0001, 8'h00, 2, 0, 16'h0000, "duty00");
        run_case(16'h0001, 16'h0001, 8'hFF, 2, PERIOD, 16'h0000, "dutyFF");
        run_case(16'hF0F1, 16'h00F1, 8'h40, 1, 256, 16'hF0F0, "mixed40");

        // Static/forced-low modes, one clk latency.
        @(posedge clk); #1;
        set_in(16'h0008, 16'h0000, 8'h00);
        @(posedge clk); #1;
        chk("static_high", int'(out), 16'h0008);
        set_in(16'h0000, 16'h0008, 8'hFF);
        @(posedge clk); #1;
        chk("en_out_low", int'(out), 16'h0000);
        set_in(16'hFFFF, 16'h00FF, 8'h00);
        @(posedge clk); #1;
        chk("pattern_pwm0", int'(out), 16'hFF00);
        set_in(16'h0FF0, 16'h0F0F, 8'hFF);
        @(posedge clk); #1;
        chk("pattern_pwmFF", int'(out), 16'h0FF0);

        // Mid-period duty change 0x40 -> 0xC0 at count 0x20.
        set_in(16'h0001, 16'h0001, 8'h40);
        wait_ps(c);
        wait_ps(c);
        k = mon_period + 1;
        push(k, SHADOW ? 256 : 768, 16'h0000, "mid_cur");
        push(k + 1, 768, 16'h0000, "mid_next");
        repeat (32 * CLK_DIV) @(posedge clk);
        #1;
        pwm_duty_cycle = 8'hC0;
        wait_ps(c);
        wait_ps(c);

        // Asynchronous reset while out[0] is high.
        set_in(16'h0001, 16'h0001, 8'h80);
        wait_ps(c);
        wait_ps(c);
        repeat (10) @(posedge clk);
        #1;
        chk("pre_reset_high", int'(out[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_out", int'(out), 0);
        chk("async_reset_ps", int'(period_start), 0);
        repeat (3) @(negedge clk);
        push(mon_period, SHADOW ? 0 : 512, 16'h0000, "post_reset_first");
        push(mon_period + 1, 512, 16'h0000, "post_reset_second");
        rst_n = 1'b1;
        wait_ps(c);
        chk("post_reset_latency", c, PERIOD);
        wait_ps(c);
        chk("post_reset_period", c, PERIOD);

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_peripheral.md
# pwm_peripheral

Consumes the five configuration registers written over SPI (output enables, PWM enables, duty cycle) and drives the 16 chip outputs. Each output is forced low, held high, or driven with a shared 8-bit PWM waveform. The block sits directly downstream of the SPI register file and shares its system clock. A prescaled 8-bit counter sets the PWM period.

## Interface
Parameters:
- `CLK_DIV`, default 3000: `clk` cycles per PWM count step; must be ≥ 1. Prescaler width is `$clog2(CLK_DIV)`, minimum 1 bit.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en_reg_out_7_0`  in  8  output enable, outputs 7:0.
- `en_reg_out_15_8`  in  8  output enable, outputs 15:8.
- `en_reg_pwm_7_0`  in  8  PWM mode select, outputs 7:0.
- `en_reg_pwm_15_8`  in  8  PWM mode select, outputs 15:8.
- `pwm_duty_cycle`  in  8  shared duty value; 0x00 = 0 %, 0xFF = 100 %.
- `out`  out  16  registered chip outputs.
- `period_start`  out  1  one-cycle pulse at each PWM counter wrap.

All inputs are synchronous to `clk`. They come from registers in the same domain, so no synchronisers are used.

## Operation
- Prescaler `pre` counts 0..`CLK_DIV`-1 and wraps.
- `tick` is asserted in the cycle where `pre == CLK_DIV-1`.
- 8-bit `count` increments on `tick` and wraps 255 to 0. PWM period = 256·`CLK_DIV` clk cycles.
- `duty_act` is the active duty value (source depends on the Configuration macro below).
- `pwm_level` = 1 if `duty_act == 8'hFF`, else (`count < duty_act`).
  - 0x00 gives constant 0.
  - 0xFF gives constant 1, with no one-count glitch.
  - Any other N gives N high counts out of 256.
- For each output i, with `en_out = {en_reg_out_15_8, en_reg_out_7_0}` and `en_pwm` concatenated the same way:
  - `en_out[i] == 0`: output is 0, regardless of `en_pwm[i]`.
  - `en_out[i] == 1`, `en_pwm[i] == 0`: output is 1 (static high).
  - `en_out[i] == 1`, `en_pwm[i] == 1`: output is `pwm_level`.
- `out` is registered from the above every cycle.
- `period_start` is a registered pulse, asserted for exactly one clk in the cycle after `tick` with `count == 255` (i.e. when `count` becomes 0).
- Enable bits take effect immediately (next clk) in both configurations. Only the duty value is subject to shadowing.

## Timing
- Reset values: `pre` = 0, `count` = 0, `duty_act` = 0, `out` = 16'h0000, `period_start` = 0.
- Reset is asynchronous. Asserting it mid-period clears `out` without waiting for a clock edge. After release, counting restarts from `pre` = 0, `count` = 0.
- Latency: a change in enables or `count` appears on `out` one clk later (single output register).
- `count` holds for `CLK_DIV` clk cycles per value. With `CLK_DIV == 1`, `tick` is constant 1 and `count` advances every clk.
- Simultaneous duty write and wrap tick (shadow mode): the new value is captured at that wrap.
- The first `period_start` after reset occurs 256·`CLK_DIV` cycles after reset release.

## Configuration
- `PWM_SHADOW_EN` defined:
  - `duty_act` is a register loaded from `pwm_duty_cycle` only on the tick where `count` wraps 255 to 0.
  - Mid-period duty writes therefore never truncate or extend the current period.
  - The first period after reset uses duty 0 (output low).
- `PWM_SHADOW_EN` undefined:
  - `duty_act` = `pwm_duty_cycle` directly, with no shadow register.
  - Writes affect the comparison in the same cycle and appear on `out` one clk later.
  - Mid-period glitches are permitted.

## Test plan
All scenarios use `CLK_DIV` = 4 (period 1024 clk) unless noted.
- Reset: hold `rst_n` = 0 with all inputs 0xFF → `out` = 0x0000, `period_start` = 0. Release → first `period_start` pulse exactly 1024 cycles later.
- Duty 0x80, `en_out` = `en_pwm` = 0x0001 → `out[0]` high for 512 consecutive clk of each 1024 and low for the rest; `out[15:1]` = 0. Count one steady-state period.
- Duty 0x00 → `out[0]` constant 0 across two full periods. Duty 0xFF → constant 1 across two full periods, no low cycle at count 255.
- Static mode: `en_out` = 0x0008, `en_pwm` = 0x0000 → `out[3]` = 1 one clk after the write. Set `en_pwm` = 0x0008 with `en_out` = 0 → `out[3]` = 0.
- Mid-period duty change 0x40 → 0xC0 at count 0x20:
  - With `PWM_SHADOW_EN`: current period shows 256 high cycles, the following period shows 768.
  - Without: high time extends in the current period, with the output high until count 0xC0.
- Reset mid-period: drop `rst_n` while `out[0]` = 1 → `out` goes to 0 before the next `clk` edge. Release → `count` restarts at 0 and full-period timing is re-established.
